// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one ME command/response channel among num_req_p miss requesters.
// Optional per-requester grant/stall counters are enabled by defining BP_ME_ARB_PERF_EN.
module bp_me_mem_cmd_arbiter #(
  parameter int unsigned num_req_p     = 2,
  parameter int unsigned paddr_width_p = 22,
  parameter int unsigned data_width_p  = 64
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p-1:0]               req_w_i,
  input  logic [num_req_p*paddr_width_p-1:0] req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]  req_data_i,
  output logic [num_req_p-1:0]               req_ready_o,
  output logic [num_req_p-1:0]               resp_v_o,
  output logic [data_width_p-1:0]            resp_data_o,
  output logic                               mem_cmd_v_o,
  output logic                               mem_cmd_w_o,
  output logic [paddr_width_p-1:0]           mem_cmd_addr_o,
  output logic [data_width_p-1:0]            mem_cmd_data_o,
  input  logic                               mem_cmd_ready_i,
  input  logic                               mem_resp_v_i,
  input  logic [data_width_p-1:0]            mem_resp_data_i,
  output logic                               mem_resp_ready_o
`ifdef BP_ME_ARB_PERF_EN
  , output logic [num_req_p*32-1:0]          perf_grant_cnt_o
  , output logic [num_req_p*32-1:0]          perf_stall_cnt_o
`endif
);

  localparam int unsigned lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [num_req_p-1:0] one_lp = {{(num_req_p-1){1'b0}}, 1'b1};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [lg_req_lp-1:0]     grant_q, grant_d;
  logic [lg_req_lp-1:0]     last_grant_q, last_grant_d;
  logic                     cmd_w_q, cmd_w_d;
  logic [paddr_width_p-1:0] cmd_addr_q, cmd_addr_d;
  logic [data_width_p-1:0]  cmd_data_q, cmd_data_d;

  logic                     found;
  logic [lg_req_lp-1:0]     winner;
  int unsigned              idx;
  logic                     resp_fire;

  // Search starts just past the last grant so every valid requester is reached within num_req_p grants.
  always_comb begin
    found  = 1'b0;
    winner = last_grant_q;
    idx    = 0;
    for (int unsigned k = 1; k <= num_req_p; k++) begin
      idx = (32'(last_grant_q) + k) % num_req_p;
      if (!found && req_v_i[idx]) begin
        found  = 1'b1;
        winner = lg_req_lp'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cmd_w_d      = cmd_w_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    unique case (state_q)
      IDLE: if (found) begin
        state_d      = CMD;
        grant_d      = winner;
        last_grant_d = winner;
        cmd_w_d      = req_w_i[winner];
        cmd_addr_d   = req_addr_i[32'(winner)*paddr_width_p +: paddr_width_p];
        cmd_data_d   = req_data_i[32'(winner)*data_width_p +: data_width_p];
      end
      CMD:  if (mem_cmd_ready_i) state_d = RESP;
      RESP: if (mem_resp_v_i)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= lg_req_lp'(num_req_p - 1);
      cmd_w_q      <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cmd_w_q      <= cmd_w_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
    end
  end

  assign resp_fire        = reset_n_i && (state_q == RESP) && mem_resp_v_i;
  assign req_ready_o      = (reset_n_i && (state_q == IDLE) && found) ? (one_lp << winner) : '0;
  assign resp_v_o         = resp_fire ? (one_lp << grant_q) : '0;
  assign resp_data_o      = resp_fire ? mem_resp_data_i : '0;
  assign mem_cmd_v_o      = (state_q == CMD);
  assign mem_cmd_w_o      = cmd_w_q;
  assign mem_cmd_addr_o   = cmd_addr_q;
  assign mem_cmd_data_o   = cmd_data_q;
  assign mem_resp_ready_o = (state_q == RESP);

`ifdef BP_ME_ARB_PERF_EN
  logic [num_req_p*32-1:0] grant_cnt_q, stall_cnt_q;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (req_ready_o[i] && (grant_cnt_q[i*32 +: 32] != '1))
          grant_cnt_q[i*32 +: 32] <= grant_cnt_q[i*32 +: 32] + 32'd1;
        if (req_v_i[i] && !req_ready_o[i] && (stall_cnt_q[i*32 +: 32] != '1))
          stall_cnt_q[i*32 +: 32] <= stall_cnt_q[i*32 +: 32] + 32'd1;
      end
    end
  end

  assign perf_grant_cnt_o = grant_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Scoreboard bench for bp_me_mem_cmd_arbiter: expected commands are queued as requests are driven
// and popped when the arbiter issues them to memory.
module tb_bp_me_mem_cmd_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 64;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req_v, req_w;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready_o, resp_v_o;
  logic [DW-1:0]     resp_data_o;
  logic              mem_cmd_v_o, mem_cmd_w_o;
  logic [AW-1:0]     mem_cmd_addr_o;
  logic [DW-1:0]     mem_cmd_data_o;
  logic              mem_cmd_ready, mem_resp_v;
  logic [DW-1:0]     mem_resp_data;
  logic              mem_resp_ready_o;
`ifdef BP_ME_ARB_PERF_EN
  logic [NR*32-1:0]  perf_grant_cnt_o, perf_stall_cnt_o;
`endif

  bp_me_mem_cmd_arbiter #(
    .num_req_p(NR), .paddr_width_p(AW), .data_width_p(DW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .req_w_i(req_w), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_w_o(mem_cmd_w_o), .mem_cmd_addr_o(mem_cmd_addr_o),
    .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_ready_i(mem_cmd_ready),
    .mem_resp_v_i(mem_resp_v), .mem_resp_data_i(mem_resp_data),
    .mem_resp_ready_o(mem_resp_ready_o)
`ifdef BP_ME_ARB_PERF_EN
    , .perf_grant_cnt_o(perf_grant_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned   req;
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [NR-1:0] oh(input int unsigned r);
    logic [NR-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int unsigned r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_v[r] = 1'b1;
    req_w[r] = w;
    req_addr[r*AW +: AW] = a;
    req_data[r*DW +: DW] = d;
  endtask

  // Entered at posedge+1 of the first CMD cycle; returns at posedge+1 of the following IDLE cycle.
  task automatic mem_serve(input int unsigned cmd_wait, input int unsigned resp_wait);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: command issued with no expected entry queued");
      return;
    end
    e = exp_q.pop_front();
    for (int unsigned c = 0; c <= cmd_wait; c++) begin
      mem_cmd_ready = (c == cmd_wait);
      @(negedge clk);
      checks++;
      if (mem_cmd_v_o !== 1'b1 || mem_cmd_w_o !== e.w || mem_cmd_addr_o !== e.addr ||
          mem_cmd_data_o !== e.wdata) begin
        errors++;
        $display("FAIL cmd_fields c=%0d: got v=%b w=%b addr=%h data=%h, want v=1 w=%b addr=%h data=%h",
                 c, mem_cmd_v_o, mem_cmd_w_o, mem_cmd_addr_o, mem_cmd_data_o, e.w, e.addr, e.wdata);
      end
      checks++;
      if (req_ready_o !== '0 || mem_resp_ready_o !== 1'b0 || resp_v_o !== '0) begin
        errors++;
        $display("FAIL cmd_quiet c=%0d: got ready=%b resp_rdy=%b resp_v=%b, want 0 0 0",
                 c, req_ready_o, mem_resp_ready_o, resp_v_o);
      end
      @(posedge clk); #1;
    end
    mem_cmd_ready = 1'b0;
    for (int unsigned c = 0; c <= resp_wait; c++) begin
      mem_resp_v    = (c == resp_wait);
      mem_resp_data = (c == resp_wait) ? e.rdata : ~e.rdata;
      @(negedge clk);
      checks++;
      if (mem_resp_ready_o !== 1'b1 || mem_cmd_v_o !== 1'b0 || req_ready_o !== '0) begin
        errors++;
        $display("FAIL resp_state c=%0d: got resp_rdy=%b cmd_v=%b ready=%b, want 1 0 0",
                 c, mem_resp_ready_o, mem_cmd_v_o, req_ready_o);
      end
      checks++;
      if (c == resp_wait) begin
        if (resp_v_o !== oh(e.req) || (!e.w && resp_data_o !== e.rdata)) begin
          errors++;
          $display("FAIL resp: got v=%b data=%h, want v=%b data=%h",
                   resp_v_o, resp_data_o, oh(e.req), e.rdata);
        end
      end else if (resp_v_o !== '0) begin
        errors++;
        $display("FAIL early_resp: got v=%b, want 0", resp_v_o);
      end
      @(posedge clk); #1;
    end
    mem_resp_v    = 1'b0;
    mem_resp_data = '0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready_o !== '0 || resp_v_o !== '0 || resp_data_o !== '0 || mem_cmd_v_o !== 1'b0 ||
        mem_resp_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b resp_v=%b rdata=%h cmd_v=%b resp_rdy=%b, want all 0",
               req_ready_o, resp_v_o, resp_data_o, mem_cmd_v_o, mem_resp_ready_o);
    end
    checks++;
    if (mem_cmd_w_o !== 1'b0 || mem_cmd_addr_o !== '0 || mem_cmd_data_o !== '0) begin
      errors++;
      $display("FAIL reset_fields: got w=%b addr=%h data=%h, want 0",
               mem_cmd_w_o, mem_cmd_addr_o, mem_cmd_data_o);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin;
    set_req(0, 1'b0, 22'h00_1000, 64'h0);
    set_req(1, 1'b0, 22'h02_2000, 64'h0);
    for (int unsigned i = 0; i < 4; i++)
      exp_q.push_back('{i % 2, 1'b0, (i % 2 == 0) ? 22'h00_1000 : 22'h02_2000, 64'h0,
                         64'h1111_0000 + 64'(i)});
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready_o !== oh(i % 2)) begin
        errors++;
        $display("FAIL rr_grant %0d: got ready=%b, want %b", i, req_ready_o, oh(i % 2));
      end
      @(posedge clk); #1;
      if (i == 3) req_v = '0;
      mem_serve(0, i % 2);
    end
  endtask

  task automatic test_single_read;
    set_req(0, 1'b0, 22'h00_1234, 64'h0);
    exp_q.push_back('{0, 1'b0, 22'h00_1234, 64'h0, 64'hDEAD_BEEF});
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL single_accept: got ready=%b, want 01", req_ready_o);
    end
    @(posedge clk); #1;
    req_v = '0;
    mem_serve(0, 0);
    @(negedge clk);
    checks++;
    if (resp_v_o !== '0 || mem_resp_ready_o !== 1'b0 || req_ready_o !== '0) begin
      errors++;
      $display("FAIL single_idle: got resp_v=%b resp_rdy=%b ready=%b, want 0 0 0",
               resp_v_o, mem_resp_ready_o, req_ready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cmd_stall;
    set_req(0, 1'b0, 22'h00_0AAA, 64'h0);
    set_req(1, 1'b1, 22'h15_5555, 64'h0123_4567_89AB_CDEF);
    exp_q.push_back('{1, 1'b1, 22'h15_5555, 64'h0123_4567_89AB_CDEF, 64'h0});
    exp_q.push_back('{0, 1'b0, 22'h00_0AAA, 64'h0, 64'hCAFE_F00D});
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL stall_accept1: got ready=%b, want 10", req_ready_o);
    end
    @(posedge clk); #1;
    req_v = 2'b01;
    mem_serve(10, 1);
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL stall_accept0: got ready=%b, want 01", req_ready_o);
    end
    @(posedge clk); #1;
    req_v = '0;
    mem_serve(0, 0);
  endtask

  task automatic test_write;
    set_req(1, 1'b1, 22'h3F_FFFF, 64'hA5A5);
    exp_q.push_back('{1, 1'b1, 22'h3F_FFFF, 64'hA5A5, 64'h0});
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL write_accept: got ready=%b, want 10", req_ready_o);
    end
    @(posedge clk); #1;
    req_v = '0;
    mem_serve(2, 0);
  endtask

  task automatic test_reset_mid;
    set_req(0, 1'b1, 22'h00_0100, 64'h77);
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL mid_accept: got ready=%b, want 01", req_ready_o);
    end
    @(posedge clk); #1;
    req_v = '0;
    mem_cmd_ready = 1'b1;
    @(posedge clk); #1;
    mem_cmd_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_resp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_resp: got resp_rdy=%b, want 1", mem_resp_ready_o);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== '0 || resp_v_o !== '0 || mem_cmd_v_o !== 1'b0 || mem_resp_ready_o !== 1'b0 ||
        mem_cmd_w_o !== 1'b0 || mem_cmd_addr_o !== '0 || mem_cmd_data_o !== '0) begin
      errors++;
      $display("FAIL mid_reset_outs: got ready=%b resp_v=%b cmd_v=%b resp_rdy=%b w=%b addr=%h data=%h, want all 0",
               req_ready_o, resp_v_o, mem_cmd_v_o, mem_resp_ready_o, mem_cmd_w_o, mem_cmd_addr_o,
               mem_cmd_data_o);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 22'h00_0200, 64'h0);
    set_req(1, 1'b0, 22'h00_0300, 64'h0);
    exp_q.push_back('{0, 1'b0, 22'h00_0200, 64'h0, 64'h2222});
    exp_q.push_back('{1, 1'b0, 22'h00_0300, 64'h0, 64'h3333});
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_grant: got ready=%b, want 01", req_ready_o);
    end
    @(posedge clk); #1;
    req_v = 2'b10;
    mem_serve(0, 0);
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_grant2: got ready=%b, want 10", req_ready_o);
    end
    @(posedge clk); #1;
    req_v = '0;
    mem_serve(0, 0);
  endtask

`ifdef BP_ME_ARB_PERF_EN
  task automatic test_perf;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_req(0, 1'b0, 22'h00_0040, 64'h0);
    set_req(1, 1'b0, 22'h00_0080, 64'h0);
    exp_q.push_back('{0, 1'b0, 22'h00_0040, 64'h0, 64'h40});
    exp_q.push_back('{1, 1'b0, 22'h00_0080, 64'h0, 64'h80});
    @(posedge clk); #1;
    req_v = 2'b10;
    mem_serve(1, 0);
    @(posedge clk); #1;
    req_v = '0;
    mem_serve(0, 0);
    @(negedge clk);
    checks++;
    if (perf_stall_cnt_o[32 +: 32] !== 32'd4 || perf_stall_cnt_o[0 +: 32] !== 32'd0) begin
      errors++;
      $display("FAIL perf_stall: got %0d/%0d, want 0/4",
               perf_stall_cnt_o[0 +: 32], perf_stall_cnt_o[32 +: 32]);
    end
    checks++;
    if (perf_grant_cnt_o[0 +: 32] !== 32'd1 || perf_grant_cnt_o[32 +: 32] !== 32'd1) begin
      errors++;
      $display("FAIL perf_grant: got %0d/%0d, want 1/1",
               perf_grant_cnt_o[0 +: 32], perf_grant_cnt_o[32 +: 32]);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    req_v         = '0;
    req_w         = '0;
    req_addr      = '0;
    req_data      = '0;
    mem_cmd_ready = 1'b0;
    mem_resp_v    = 1'b0;
    mem_resp_data = '0;
    test_reset();
    test_round_robin();
    test_single_read();
    test_cmd_stall();
    test_write();
    test_reset_mid();
`ifdef BP_ME_ARB_PERF_EN
    test_perf();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d queued entries, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
